// File: rtl/wb_arbiter.sv
// Writeback arbiter: merges single-cycle ALU results and FIFO-buffered LSU results
// onto the GPR write port, with read-after-write bypass of the in-flight write.
module wb_arbiter #(
  parameter int DATA_WIDTH     = 32,
  parameter int GPR_ADDR_WIDTH = 5,
  parameter int LSU_DEPTH      = 4
) (
  input  logic                      wb_clk,
  input  logic                      wb_rst,
  input  logic                      alu_valid,
  input  logic [GPR_ADDR_WIDTH-1:0] alu_rd,
  input  logic [DATA_WIDTH-1:0]     alu_data,
  output logic                      alu_stall,
  input  logic                      lsu_valid,
  input  logic [GPR_ADDR_WIDTH-1:0] lsu_rd,
  input  logic [DATA_WIDTH-1:0]     lsu_data,
  output logic                      lsu_ready,
  output logic                      wr_data_en,
  output logic [GPR_ADDR_WIDTH-1:0] rd,
  output logic [DATA_WIDTH-1:0]     wr_data,
  input  logic [GPR_ADDR_WIDTH-1:0] rs1,
  input  logic [GPR_ADDR_WIDTH-1:0] rs2,
  output logic                      fwd_rs1_hit,
  output logic [DATA_WIDTH-1:0]     fwd_rs1_data,
  output logic                      fwd_rs2_hit,
  output logic [DATA_WIDTH-1:0]     fwd_rs2_data
);

  localparam int PTR_W = $clog2(LSU_DEPTH);
  localparam int CNT_W = $clog2(LSU_DEPTH + 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(LSU_DEPTH);

  typedef enum logic [1:0] {SEL_NONE, SEL_ALU, SEL_LSU} sel_e;

  logic [GPR_ADDR_WIDTH-1:0] r_fifo_rd   [LSU_DEPTH];
  logic [DATA_WIDTH-1:0]     r_fifo_data [LSU_DEPTH];
  logic [PTR_W-1:0]          r_wptr;
  logic [PTR_W-1:0]          r_rptr;
  logic [CNT_W-1:0]          r_count;

  logic                      r_wr_en;
  logic [GPR_ADDR_WIDTH-1:0] r_rd;
  logic [DATA_WIDTH-1:0]     r_wr_data;

  logic w_full;
  logic w_empty;
  logic w_push;
  logic w_pop;
  sel_e w_sel;

  assign w_full    = (r_count == FULL_CNT);
  assign w_empty   = (r_count == '0);
  assign lsu_ready = !w_full && !wb_rst;
  assign w_push    = lsu_valid && lsu_ready;

  // A full FIFO outranks the ALU so LSU results cannot starve behind a busy ALU.
  always_comb begin
    w_sel     = SEL_NONE;
    w_pop     = 1'b0;
    alu_stall = 1'b0;
    if (w_full && alu_valid) begin
      w_sel     = SEL_LSU;
      w_pop     = 1'b1;
      alu_stall = 1'b1;
    end else if (alu_valid) begin
      w_sel = SEL_ALU;
    end else if (!w_empty) begin
      w_sel = SEL_LSU;
      w_pop = 1'b1;
    end
  end

  always_ff @(posedge wb_clk) begin
    if (w_push) begin
      r_fifo_rd[r_wptr]   <= lsu_rd;
      r_fifo_data[r_wptr] <= lsu_data;
    end
  end

  always_ff @(posedge wb_clk or posedge wb_rst) begin
    if (wb_rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge wb_clk or posedge wb_rst) begin
    if (wb_rst) begin
      r_wr_en   <= 1'b0;
      r_rd      <= '0;
      r_wr_data <= '0;
    end else begin
      r_wr_en <= 1'b0;
      case (w_sel)
        SEL_ALU: begin
          r_wr_en   <= (alu_rd != '0);
          r_rd      <= alu_rd;
          r_wr_data <= alu_data;
        end
        SEL_LSU: begin
          r_wr_en   <= (r_fifo_rd[r_rptr] != '0);
          r_rd      <= r_fifo_rd[r_rptr];
          r_wr_data <= r_fifo_data[r_rptr];
        end
        default: ;
      endcase
    end
  end

  assign wr_data_en = r_wr_en;
  assign rd         = r_rd;
  assign wr_data    = r_wr_data;

  assign fwd_rs1_hit  = r_wr_en && (r_rd == rs1) && (rs1 != '0);
  assign fwd_rs1_data = fwd_rs1_hit ? r_wr_data : '0;
  assign fwd_rs2_hit  = r_wr_en && (r_rd == rs2) && (rs2 != '0);
  assign fwd_rs2_data = fwd_rs2_hit ? r_wr_data : '0;

endmodule
